// File: rtl/adder_rr_arbiter_if.sv
// rtl/adder_rr_arbiter_if.sv - request, adder and response signals of the shared-adder arbiter
interface adder_rr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_cin;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic                   add_cin;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_cout;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_cout;

  modport master (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one external adder among N_REQ requesters
module adder_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  adder_rr_arbiter_if.master  bus,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state;
  state_t             next_state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    offset;
  logic [ID_W:0]      base;
  logic [ID_W:0]      gsum;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;
  logic               any_valid;
  logic               accept;

  // Rotate the valids so the requester after last_grant sits at bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  always_comb begin
    base    = {1'b0, last_grant} + (ID_W+1)'(1);
    shifted = {bus.req_valid, bus.req_valid} >> base;
    rot     = shifted[N_REQ-1:0];
    offset  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = ID_W'(k);
    end
    gsum = base + {1'b0, offset};
    if (gsum >= (ID_W+1)'(N_REQ)) gsum = gsum - (ID_W+1)'(N_REQ);
    grant     = gsum[ID_W-1:0];
    any_valid = |bus.req_valid;
  end

  assign accept = (state == IDLE) && any_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = ISSUE;
      ISSUE:   next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = (state == RESP);
    if (accept && !rst) bus.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (next_state != IDLE);
  end

  // Operands are latched only on accept; the result only in ISSUE, so both hold through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.add_a    <= '0;
      bus.add_b    <= '0;
      bus.add_cin  <= 1'b0;
      bus.rsp_id   <= '0;
      bus.rsp_sum  <= '0;
      bus.rsp_cout <= 1'b0;
      last_grant   <= ID_W'(N_REQ - 1);
    end else begin
      if (accept) begin
        bus.add_a   <= bus.req_a[grant*WIDTH +: WIDTH];
        bus.add_b   <= bus.req_b[grant*WIDTH +: WIDTH];
        bus.add_cin <= bus.req_cin[grant];
        bus.rsp_id  <= grant;
        last_grant  <= grant;
      end
      if (state == ISSUE) begin
        bus.rsp_sum  <= bus.add_sum;
        bus.rsp_cout <= bus.add_cout;
      end
    end
  end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - self-checking bench for adder_rr_arbiter
module tb_adder_rr_arbiter;
  localparam int WIDTH = 16;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_model;

  adder_rr_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  adder_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // External ripple-carry adder stand-in
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(input logic [N_REQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (last + k) % N_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [16:0] model_sum(input int r);
    return {1'b0, bus.req_a[r*WIDTH +: WIDTH]} + {1'b0, bus.req_b[r*WIDTH +: WIDTH]} + 17'(bus.req_cin[r]);
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_cin[i] = cin;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic wait_accept(output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (|bus.req_ready) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rand_ops();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, busy, bus.rsp_id, bus.rsp_cout} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0", {bus.req_ready, bus.rsp_valid, busy, bus.rsp_id, bus.rsp_cout});
    end
    checks++;
    if ({bus.add_a, bus.add_b, bus.add_cin, bus.rsp_sum} !== 49'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {bus.add_a, bus.add_b, bus.add_cin, bus.rsp_sum});
    end
    @(negedge clk);
    rst = 1'b0;
    last_model = N_REQ - 1;
  endtask

  task automatic test_fairness();
    int t, prev, exp;
    bit ok;
    logic [16:0] s;
    rand_ops();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_accept(t, ok);
      exp = pick(4'hF, last_model);
      checks++;
      if (!ok || bus.req_ready !== 4'(1 << exp)) begin
        errors++;
        $display("FAIL fair_grant%0d: got %b expected %b", n, bus.req_ready, 4'(1 << exp));
      end
      if (n > 0) begin
        checks++;
        if (t - prev !== 3) begin
          errors++;
          $display("FAIL fair_spacing%0d: got %0d expected 3", n, t - prev);
        end
      end
      prev = t;
      last_model = exp;
      s = model_sum(exp);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b1, ID_W'(exp), s}) begin
        errors++;
        $display("FAIL fair_rsp%0d: got %h expected %h", n, {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {1'b1, ID_W'(exp), s});
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t;
    bit ok;
    set_req(0, 16'h1234, 16'h0001, 1'b0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    wait_accept(t, ok);
    checks++;
    if (!ok || bus.req_ready !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got ready=%b busy=%b expected ready=0001 busy=0", bus.req_ready, busy);
    end
    last_model = 0;
    @(negedge clk);
    bus.req_valid = '0;
    rand_ops();
    #1;
    checks++;
    if ({busy, bus.rsp_valid, bus.req_ready, bus.add_a, bus.add_b, bus.add_cin} !== {2'b10, 4'b0000, 16'h1234, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL single_issue: got %h expected %h", {busy, bus.rsp_valid, bus.req_ready, bus.add_a, bus.add_b, bus.add_cin},
               {2'b10, 4'b0000, 16'h1234, 16'h0001, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, busy, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {2'b11, 2'd0, 1'b0, 16'h1235}) begin
      errors++;
      $display("FAIL single_rsp: got %h expected %h", {bus.rsp_valid, busy, bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {2'b11, 2'd0, 1'b0, 16'h1235});
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: got %b expected 00", {bus.rsp_valid, busy});
    end
  endtask

  task automatic test_carry();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic        tc [3];
    logic [16:0] s;
    int t;
    bit ok;
    ta[0] = 16'hFFFF; tb[0] = 16'h0001; tc[0] = 1'b1;
    ta[1] = 16'h8000; tb[1] = 16'h8000; tc[1] = 1'b0;
    ta[2] = 16'hFFFF; tb[2] = 16'hFFFF; tc[2] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_req(2, ta[n], tb[n], tc[n]);
      s = {1'b0, ta[n]} + {1'b0, tb[n]} + 17'(tc[n]);
      bus.req_valid = 4'b0100;
      wait_accept(t, ok);
      checks++;
      if (!ok || bus.req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL carry_accept%0d: got %b expected 0100", n, bus.req_ready);
      end
      last_model = 2;
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b1, 2'd2, s}) begin
        errors++;
        $display("FAIL carry_rsp%0d: got %h expected %h", n, {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {1'b1, 2'd2, s});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_priority_resume();
    int t, exp;
    bit ok;
    logic [16:0] s;
    rand_ops();
    bus.req_valid = 4'b0010;
    wait_accept(t, ok);
    checks++;
    if (!ok || bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL prio_first: got %b expected 0010", bus.req_ready);
    end
    last_model = 1;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rand_ops();
    bus.req_valid = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      wait_accept(t, ok);
      exp = pick(4'b1010, last_model);
      checks++;
      if (!ok || bus.req_ready !== 4'(1 << exp)) begin
        errors++;
        $display("FAIL prio_grant%0d: got %b expected %b", n, bus.req_ready, 4'(1 << exp));
      end
      last_model = exp;
      s = model_sum(exp);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {ID_W'(exp), s}) begin
        errors++;
        $display("FAIL prio_rsp%0d: got %h expected %h", n, {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {ID_W'(exp), s});
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int t;
    bit ok;
    logic [16:0] s0, s1;
    rand_ops();
    s0 = model_sum(0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    wait_accept(t, ok);
    checks++;
    if (!ok || bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_accept: got %b expected 0001", bus.req_ready);
    end
    last_model = 0;
    @(negedge clk);
    rand_ops();
    s1 = model_sum(1);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if ({bus.rsp_valid, busy, bus.req_ready, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {2'b11, 4'b0000, 2'd0, s0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h expected %h", n, {bus.rsp_valid, busy, bus.req_ready, bus.rsp_id, bus.rsp_cout, bus.rsp_sum},
                 {2'b11, 4'b0000, 2'd0, s0});
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL bp_release: got %b expected 10000", {bus.rsp_valid, bus.req_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 5'b00010) begin
      errors++;
      $display("FAIL bp_next_accept: got %b expected 00010", {bus.rsp_valid, bus.req_ready});
    end
    last_model = 1;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b1, 2'd1, s1}) begin
      errors++;
      $display("FAIL bp_rsp1: got %h expected %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {1'b1, 2'd1, s1});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int t;
    bit ok;
    logic [16:0] s;
    rand_ops();
    set_req(1, 16'h8000 | 16'($urandom), 16'($urandom), 1'b1);
    bus.req_valid = 4'b0010;
    wait_accept(t, ok);
    checks++;
    if (!ok || bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_accept: got %b expected 0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, busy, bus.rsp_sum, bus.add_a} !== 34'd0) begin
      errors++;
      $display("FAIL rst_clear: got %h expected 0", {bus.rsp_valid, busy, bus.rsp_sum, bus.add_a});
    end
    @(negedge clk);
    rst = 1'b0;
    last_model = N_REQ - 1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if ({bus.rsp_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL rst_no_rsp%0d: got %b expected 00", n, {bus.rsp_valid, busy});
      end
      @(negedge clk);
    end
    rand_ops();
    bus.req_valid = 4'b1001;
    wait_accept(t, ok);
    checks++;
    if (!ok || bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_priority: got %b expected 0001", bus.req_ready);
    end
    last_model = 0;
    s = model_sum(0);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {1'b1, 2'd0, s}) begin
      errors++;
      $display("FAIL rst_rsp: got %h expected %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, {1'b1, 2'd0, s});
    end
    @(negedge clk);
  endtask

  // Transaction-level model: one outstanding op, response from two cycles after accept until consumed.
  task automatic test_random();
    bit          pending = 1'b0;
    int          acc = 0;
    int          p;
    logic [3:0]  exp_ready;
    logic [ID_W-1:0] exp_id = '0;
    logic [16:0] exp_s = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rand_ops();
      bus.req_valid = 4'($urandom);
      bus.rsp_ready = ($urandom % 3) != 0;
      #1;
      if (!pending) begin
        p = pick(bus.req_valid, last_model);
        exp_ready = (p < 0) ? 4'b0000 : 4'(1 << p);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, busy} !== {exp_ready, 2'b00}) begin
          errors++;
          $display("FAIL rand_idle%0d: got %b expected %b", n, {bus.req_ready, bus.rsp_valid, busy}, {exp_ready, 2'b00});
        end
        if (p >= 0) begin
          pending    = 1'b1;
          acc        = cyc;
          exp_id     = ID_W'(p);
          exp_s      = model_sum(p);
          last_model = p;
        end
      end else if (cyc - acc == 1) begin
        checks++;
        if ({bus.req_ready, bus.rsp_valid, busy} !== 6'b000001) begin
          errors++;
          $display("FAIL rand_issue%0d: got %b expected 000001", n, {bus.req_ready, bus.rsp_valid, busy});
        end
      end else begin
        checks++;
        if ({bus.req_ready, bus.rsp_valid, busy, bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== {6'b000011, exp_id, exp_s}) begin
          errors++;
          $display("FAIL rand_rsp%0d: got %h expected %h", n, {bus.req_ready, bus.rsp_valid, busy, bus.rsp_id, bus.rsp_cout, bus.rsp_sum},
                   {6'b000011, exp_id, exp_s});
        end
        if (bus.rsp_ready) pending = 1'b0;
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    last_model    = N_REQ - 1;
    test_reset();
    test_fairness();
    test_single();
    test_carry();
    test_priority_resume();
    test_back_pressure();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
